// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with a two-entry skid buffer, synchronous flush that
// inserts a zero-control bubble, and a saturating stall counter.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 80,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic acc_in, acc_out;

  assign acc_in  = in_valid & in_ready_q;
  assign acc_out = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    out_ctrl_d  = out_ctrl_q;
    out_data_d  = out_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Flush wins over both handshakes; the upstream item this cycle is dropped.
      state_d     = ST_EMPTY;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      out_ctrl_d  = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc_in) begin
            out_ctrl_d  = in_ctrl;
            out_data_d  = in_data;
            out_valid_d = 1'b1;
            state_d     = ST_FULL;
          end
        end
        ST_FULL: begin
          if (acc_in && acc_out) begin
            out_ctrl_d = in_ctrl;
            out_data_d = in_data;
          end else if (acc_in) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            in_ready_d  = 1'b0;
            state_d     = ST_SKID;
          end else if (acc_out) begin
            out_valid_d = 1'b0;
            out_ctrl_d  = '0;
            state_d     = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (acc_out) begin
            out_ctrl_d = skid_ctrl_q;
            out_data_d = skid_data_q;
            in_ready_d = 1'b1;
            state_d    = ST_FULL;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          out_ctrl_d  = '0;
        end
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_ctrl_q  <= '0;
      out_data_q  <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      out_ctrl_q  <= out_ctrl_d;
      out_data_q  <= out_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_data  = out_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted items are queued, a monitor
// pops and compares each downstream handshake; directed checks cover the rest.
module tb_pipe_stage_reg;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 80;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic              clr_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } item_t;

  item_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .flush     (flush),
    .clr_cnt   (clr_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every downstream handshake consumes the oldest expected item.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_item: got ctrl=%0h data=%0h expected none", out_ctrl, out_data);
      end else begin
        item_t e;
        e = exp_q.pop_front();
        if (out_ctrl !== e.ctrl || out_data !== e.data) begin
          n_err++;
          $display("FAIL out_item: got ctrl=%0h data=%0h expected ctrl=%0h data=%0h",
                   out_ctrl, out_data, e.ctrl, e.data);
        end else begin
          $display("ok   out_item: ctrl=%0h data=%0h", out_ctrl, out_data);
        end
      end
    end
  end

  // One clock: sample the handshake mid-cycle, update the scoreboard at the
  // edge, then return 1 time unit later so the caller can drive and check.
  task automatic cyc();
    logic  acc, drop;
    item_t it;
    @(negedge clk);
    acc  = rst_n && !flush && in_valid && (in_ready === 1'b1);
    drop = !rst_n || flush;
    it.ctrl = in_ctrl;
    it.data = in_data;
    @(posedge clk);
    if (drop) exp_q.delete();
    else if (acc) exp_q.push_back(it);
    #1;
  endtask

  task automatic present(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
    present(8'h5A, 80'h1);

    // Reset with in_valid high, then release: A appears one cycle later.
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ctrl",  out_ctrl, 8'h00);
    chk("rst_out_data",  out_data, 80'h0);
    chk("rst_in_ready",  in_ready, 1'b1);
    chk("rst_stall_cnt", stall_cnt, 4'd0);
    rst_n = 1'b1;
    cyc();
    chk("a_out_valid", out_valid, 1'b1);
    chk("a_out_ctrl",  out_ctrl, 8'h5A);
    in_valid = 1'b0;
    cyc();
    chk("drain_out_valid", out_valid, 1'b0);
    chk("drain_out_ctrl",  out_ctrl, 8'h00);
    chk("drain_out_data",  out_data, 80'h1);

    // Streaming: 16 back-to-back items, latency 1, in_ready never drops.
    for (int i = 0; i < 16; i++) begin
      present(8'h10 + 8'(i), 80'h1000 + 80'(i));
      cyc();
      chk("stream_in_ready", in_ready, 1'b1);
      chk("stream_out_ctrl", out_ctrl, 8'h10 + 8'(i));
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_end_valid", out_valid, 1'b0);
    chk("stream_stall_cnt", stall_cnt, 4'd0);

    // Back-pressure: A in output, B into skid, C held upstream.
    out_ready = 1'b0;
    present(8'hA1, 80'hAAA);
    cyc();
    chk("bp_a_valid", out_valid, 1'b1);
    present(8'hB2, 80'hBBB);
    cyc();
    chk("bp_skid_in_ready", in_ready, 1'b0);
    chk("bp_cnt1", stall_cnt, 4'd1);
    present(8'hC3, 80'hCCC);
    cyc();
    chk("bp_hold_in_ready", in_ready, 1'b0);
    chk("bp_cnt2", stall_cnt, 4'd2);
    cyc();
    chk("bp_cnt3", stall_cnt, 4'd3);
    chk("bp_hold_ctrl", out_ctrl, 8'hA1);
    out_ready = 1'b1;
    cyc();
    chk("bp_b_out_ctrl", out_ctrl, 8'hB2);
    chk("bp_in_ready_back", in_ready, 1'b1);
    chk("bp_cnt_hold", stall_cnt, 4'd3);
    cyc();
    chk("bp_c_out_ctrl", out_ctrl, 8'hC3);
    in_valid = 1'b0;
    cyc();
    chk("bp_empty", out_valid, 1'b0);

    // Flush in SKID while D is presented: D must not be captured.
    out_ready = 1'b0;
    present(8'hE5, 80'hEEE);
    cyc();
    present(8'hF6, 80'hFFF);
    cyc();
    chk("fl_skid_in_ready", in_ready, 1'b0);
    present(8'hD4, 80'hDDD);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_out_ctrl",  out_ctrl, 8'h00);
    chk("fl_in_ready",  in_ready, 1'b1);
    chk("fl_cnt_kept",  stall_cnt, 4'd5);
    cyc();
    chk("fl_no_capture", out_valid, 1'b0);
    out_ready = 1'b1;
    present(8'hD4, 80'hDDD);
    cyc();
    chk("fl_d_reaccepted", out_ctrl, 8'hD4);
    in_valid = 1'b0;
    cyc();
    chk("fl_d_drained", out_valid, 1'b0);

    // Counter saturation at 15 with clr priority.
    out_ready = 1'b0;
    clr_cnt = 1'b1;
    present(8'h77, 80'h777);
    cyc();
    clr_cnt = 1'b0;
    in_valid = 1'b0;
    chk("cnt_cleared", stall_cnt, 4'd0);
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 3 || i == 15 || i == 20)
        chk("cnt_sat", stall_cnt, (i > 15) ? 4'd15 : 4'(i));
    end
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("cnt_clr", stall_cnt, 4'd0);
    cyc();
    chk("cnt_resume", stall_cnt, 4'd1);
    out_ready = 1'b1;
    cyc();
    chk("cnt_drain_valid", out_valid, 1'b0);
    chk("cnt_drain_hold", stall_cnt, 4'd1);

    // Reset together with flush mid-transfer: reset result wins.
    out_ready = 1'b0;
    present(8'h99, 80'h999);
    cyc();
    in_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    flush = 1'b1;
    cyc();
    rst_n = 1'b1;
    flush = 1'b0;
    chk("rf_out_valid", out_valid, 1'b0);
    chk("rf_out_data",  out_data, 80'h0);
    chk("rf_stall_cnt", stall_cnt, 4'd0);
    chk("rf_in_ready",  in_ready, 1'b1);

    out_ready = 1'b1;
    cyc(); cyc();
    chk("sb_empty", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
